uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_byte_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the byte-wide UART receiver.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;
`endif

    // Clocks per oversample tick, rounded to the nearest integer.
    function automatic int calcDiv(input longint clkHz, input longint baud);
        longint denom;
        denom = baud * longint'(OVERSAMPLE);
        return int'((clkHz + denom / 2) / denom);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable so
// the tick phase can be aligned to the start-bit falling edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int DIV = calcDiv(longint'(CLK_FREQ_HZ), longint'(BAUD));
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_divCheck
            $error("uart_baud_tick: clock too slow for 16x oversampling at this baud rate");
        end
    endgenerate

    logic [CW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == CW'(DIV - 1));
    assign tick   = w_wrap;

    // Free-running divider, zeroed on restart so the next tick lands DIV clocks later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (restart || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a
// 16x oversampled midpoint sampler and an AXI-Stream style byte output.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam logic [3:0] START_MID = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] BIT_MID   = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 r_rxdMeta;
    logic                 r_rxdSync;
    logic                 r_rxdPrev;
    logic [1:0]           r_settle;

    rx_state_t            r_state;
    logic [3:0]           r_tickCnt;
    logic [2:0]           r_bitCnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_waitHigh;
    logic                 r_doneValid;
    logic [DATA_BITS-1:0] r_doneData;
    logic                 r_frameErr;
`ifdef UART_RX_PARITY_EN
    logic                 r_parityBad;
    logic                 r_parityErr;
`endif

    logic [DATA_BITS-1:0] r_tdata;
    logic                 r_tvalid;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_fall;
    logic                 w_restart;
    logic                 w_startMid;
    logic                 w_bitMid;

    // Edges are ignored until the reset value has flushed out of the
    // synchronizer, so a line that is already low is not mistaken for a start bit.
    assign w_fall     = (r_settle == 2'd3) && r_rxdPrev && !r_rxdSync;
    assign w_restart  = (r_state == ST_IDLE) && w_fall;
    assign w_startMid = w_tick && (r_tickCnt == START_MID);
    assign w_bitMid   = w_tick && (r_tickCnt == BIT_MID);

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign frame_err     = r_frameErr;
    assign overrun       = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err    = r_parityErr;
`endif

    uart_baud_tick #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD)
    ) u_baudTick (
        .clk    (clk),
        .rst    (rst),
        .restart(w_restart),
        .tick   (w_tick)
    );

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxdMeta <= 1'b1;
            r_rxdSync <= 1'b1;
            r_rxdPrev <= 1'b1;
            r_settle  <= 2'd0;
        end else begin
            r_rxdMeta <= rxd;
            r_rxdSync <= r_rxdMeta;
            r_rxdPrev <= r_rxdSync;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    // Frame state machine: samples each bit at its midpoint tick and hands completed bytes on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tickCnt   <= 4'd0;
            r_bitCnt    <= 3'd0;
            r_shift     <= '0;
            r_waitHigh  <= 1'b0;
            r_doneValid <= 1'b0;
            r_doneData  <= '0;
            r_frameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parityBad <= 1'b0;
            r_parityErr <= 1'b0;
`endif
        end else begin
            r_doneValid <= 1'b0;
            r_frameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parityErr <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_tickCnt  <= 4'd0;
                    r_bitCnt   <= 3'd0;
                    r_waitHigh <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    r_parityBad <= 1'b0;
`endif
                    if (w_fall) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tickCnt <= r_tickCnt + 4'd1;
                    end
                    if (w_startMid) begin
                        r_tickCnt <= 4'd0;
                        r_state   <= r_rxdSync ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_tickCnt <= r_tickCnt + 4'd1;
                    end
                    if (w_bitMid) begin
                        r_shift  <= {r_rxdSync, r_shift[DATA_BITS-1:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tickCnt <= r_tickCnt + 4'd1;
                    end
                    if (w_bitMid) begin
                        if ((^r_shift) != r_rxdSync) begin
                            r_parityBad <= 1'b1;
                            r_parityErr <= 1'b1;
                        end
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (r_waitHigh) begin
                        if (r_rxdSync) begin
                            r_waitHigh <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end else begin
                        if (w_tick) begin
                            r_tickCnt <= r_tickCnt + 4'd1;
                        end
                        if (w_bitMid) begin
                            if (r_rxdSync) begin
`ifdef UART_RX_PARITY_EN
                                r_doneValid <= !r_parityBad;
`else
                                r_doneValid <= 1'b1;
`endif
                                r_doneData  <= r_shift;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_frameErr <= 1'b1;
                                r_waitHigh <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output holding register: a new byte loads if the slot is empty or being drained, else it is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_doneValid) begin
                if (!r_tvalid || m_axis_tready) begin
                    r_tdata  <= r_doneData;
                    r_tvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Testbench for uart_byte_rx: serial frames are driven bit by bit, expected
// bytes go into a queue and a monitor pops them on every output handshake.
// Build with UART_RX_PARITY_EN to exercise the parity variant.
`timescale 1ns/1ps
module tb_uart_byte_rx;

    localparam int CLK_HZ    = 100000000;
    localparam int BAUD_RATE = 115200;
    // Receiver bit period: 16 ticks of round(clk / (baud*16)) clocks.
    localparam int BIT_CLKS  = ((CLK_HZ + BAUD_RATE * 8) / (BAUD_RATE * 16)) * 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int NUM_RANDOM = 0;
`else
    localparam int FRAME_BITS = 10;
    localparam int NUM_RANDOM = 2;
`endif
    localparam int STOP_MID_CLKS = BIT_CLKS * (FRAME_BITS - 1) + BIT_CLKS / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       frameErr;
    logic       overrunP;
`ifdef UART_RX_PARITY_EN
    logic       parityErr;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    int frameErrCycles = 0;
    int overrunCycles  = 0;
    int parityErrCycles = 0;
    int validRises     = 0;
    int lastRiseCyc    = 0;
    int lastStartCyc   = 0;
    int stableErr      = 0;
    int expFrameErr    = 0;
    int expParityErr   = 0;
    bit abortTx        = 1'b0;

    logic [7:0] expQ[$];

    logic       prevValid = 1'b0;
    logic       prevReady = 1'b0;
    logic [7:0] prevData  = 8'h00;

    uart_byte_rx #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD       (BAUD_RATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .frame_err    (frameErr),
`ifdef UART_RX_PARITY_EN
        .parity_err   (parityErr),
`endif
        .overrun      (overrunP)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pulse counting, hold-stability and scoreboard comparison on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
            prevReady = 1'b0;
        end else begin
            if (frameErr) frameErrCycles++;
            if (overrunP) overrunCycles++;
`ifdef UART_RX_PARITY_EN
            if (parityErr) parityErrCycles++;
`endif
            if (tvalid && !prevValid) begin
                validRises++;
                lastRiseCyc = cyc;
            end
            if (prevValid && !prevReady && tvalid && (tdata !== prevData)) stableErr++;
            if (tvalid && tready) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpectedByte: got 0x%0h, required no byte", tdata);
                end else begin
                    checkOutput("rxByte", {24'h0, tdata}, {24'h0, expQ.pop_front()});
                end
            end
            prevValid = tvalid;
            prevReady = tready;
            prevData  = tdata;
        end
    end

    initial begin
        #1200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic driveBit(input logic v);
        rxd = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    // Drives one serial frame; parity (when built in) is even parity, optionally inverted.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic flip);
        @(posedge clk);
        #1;
        lastStartCyc = cyc;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (!abortTx) driveBit(b[i]);
        end
`ifdef UART_RX_PARITY_EN
        if (!abortTx) driveBit((^b) ^ flip);
`else
        if (flip) $display("[TB] note: parity flip ignored in 8N1 build");
`endif
        if (!abortTx) driveBit(stopBit);
    endtask

    // Reference model: a frame yields a byte only if its stop bit is high and its parity is right.
    task automatic issueFrame(input logic [7:0] b, input logic stopBit, input logic flip, input bit jitter);
        bit good;
        good = stopBit;
`ifdef UART_RX_PARITY_EN
        if (flip) begin
            good = 1'b0;
            expParityErr++;
        end
`endif
        if (good) expQ.push_back(b);
        if (!stopBit) expFrameErr++;
        if (jitter) begin
            fork
                applyStimulus(b, stopBit, flip);
                begin
                    repeat (BIT_CLKS * FRAME_BITS) begin
                        @(posedge clk);
                        #1;
                        tready = 1'($urandom_range(0, 1));
                    end
                end
            join
            tready = 1'b1;
        end else begin
            applyStimulus(b, stopBit, flip);
        end
    endtask

    initial begin
        int base;
        int baseErr;
        int diff;
        logic [7:0] rb;

        rst    = 1'b1;
        rxd    = 1'b1;
        tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetTvalid", {31'h0, tvalid}, 32'h0);
        checkOutput("resetTdata", {24'h0, tdata}, 32'h0);
        checkOutput("resetFrameErr", {31'h0, frameErr}, 32'h0);
        checkOutput("resetOverrun", {31'h0, overrunP}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);

        $display("[TB] byte 0xA5 with tready high");
        base = validRises;
        issueFrame(8'hA5, 1'b1, 1'b0, 1'b0);
        diff = lastRiseCyc - lastStartCyc;
        checkOutput($sformatf("a5LatencyWindow(diff=%0d)", diff),
                    {31'h0, (diff >= STOP_MID_CLKS) && (diff <= STOP_MID_CLKS + 8)}, 32'h1);
        checkOutput("a5SinglePulse", validRises - base, 1);
        checkOutput("a5TvalidLow", {31'h0, tvalid}, 32'h0);

        $display("[TB] bytes 0x00, 0xFF back to back with tready low");
        tready = 1'b0;
        base = overrunCycles;
        expQ.push_back(8'h00);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("overrunHoldValid", {31'h0, tvalid}, 32'h1);
        checkOutput("overrunHoldData", {24'h0, tdata}, 32'h00);
        checkOutput("overrunPulse", overrunCycles - base, 1);
        @(posedge clk);
        #1 tready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("overrunDrained", {31'h0, tvalid}, 32'h0);
        checkOutput("overrunQueueEmpty", expQ.size(), 0);

        $display("[TB] 300-clock glitch");
        base    = validRises;
        baseErr = frameErrCycles;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (300) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        checkOutput("glitchNoByte", validRises - base, 0);
        checkOutput("glitchNoFrameErr", frameErrCycles - baseErr, 0);

        $display("[TB] 0x3C with low stop bit followed by a break, then 0x55");
        base    = validRises;
        baseErr = frameErrCycles;
        issueFrame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        checkOutput("breakOneFrameErr", frameErrCycles - baseErr, 1);
        checkOutput("breakNoByte", validRises - base, 0);
        issueFrame(8'h55, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        checkOutput("after3cByteCount", validRises - base, 1);
        checkOutput("after3cQueueEmpty", expQ.size(), 0);

        $display("[TB] reset in the middle of 0x81, then 0x7E");
        base = validRises;
        fork
            applyStimulus(8'h81, 1'b1, 1'b0);
            begin
                repeat (BIT_CLKS * 4 + BIT_CLKS / 2) @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                checkOutput("midResetTvalid", {31'h0, tvalid}, 32'h0);
                checkOutput("midResetTdata", {24'h0, tdata}, 32'h0);
                checkOutput("midResetFrameErr", {31'h0, frameErr}, 32'h0);
                checkOutput("midResetOverrun", {31'h0, overrunP}, 32'h0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                abortTx = 1'b1;
            end
        join
        rxd = 1'b1;
        abortTx = 1'b0;
        repeat (2 * BIT_CLKS) @(posedge clk);
        checkOutput("cutFrameNoByte", validRises - base, 0);
        issueFrame(8'h7E, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        checkOutput("after7eQueueEmpty", expQ.size(), 0);

        $display("[TB] random bytes with random tready");
        for (int i = 0; i < NUM_RANDOM; i++) begin
            rb = 8'($urandom_range(0, 255));
            issueFrame(rb, 1'b1, 1'b0, 1'b1);
        end
        repeat (20) @(posedge clk);
        checkOutput("randomQueueEmpty", expQ.size(), 0);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity: 0x01 with wrong then right parity bit");
        base = validRises;
        issueFrame(8'h01, 1'b1, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        checkOutput("parityBadNoByte", validRises - base, 0);
        checkOutput("parityErrPulse", parityErrCycles, 1);
        issueFrame(8'h01, 1'b1, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        checkOutput("parityGoodQueueEmpty", expQ.size(), 0);
        checkOutput("parityErrTotal", parityErrCycles, expParityErr);
`endif

        checkOutput("frameErrTotal", frameErrCycles, expFrameErr);
        checkOutput("overrunTotal", overrunCycles, 1);
        checkOutput("tdataStableWhileHeld", stableErr, 0);
        checkOutput("finalQueueEmpty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
